// File: rtl/mem_arbiter.sv
// mem_arbiter: four-requester round-robin arbiter in front of a memory port
// that allows a single outstanding transaction (IDLE -> ISSUE -> WAIT).
// Optional feature macro: MEM_ARB_TIMEOUT_EN -- aborts a WAIT that lasts
// TIMEOUT_CYCLES cycles, sets a sticky timeout_err and returns a zero-data
// response. Without the macro timeout_err is tied low and WAIT lasts until
// a matching ack arrives.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    req_rd_en,
    input  logic [15:0]    req_wr_en,
    input  logic [8191:0]  req_addr,
    input  logic [32767:0] req_wr_data,
    input  logic [255:0]   req_wr_mask,
    input  logic [19:0]    req_tag,
    output logic [3:0]     req_grant,
    output logic [3:0]     resp_valid,
    output logic [4:0]     resp_tag,
    output logic [8191:0]  resp_rd_data,
    output logic [3:0]     mem_rd_en,
    output logic [3:0]     mem_wr_en,
    output logic [2047:0]  mem_addr,
    output logic [8191:0]  mem_wr_data,
    output logic [63:0]    mem_wr_mask,
    output logic [6:0]     mem_tag,
    input  logic [8191:0]  mem_rd_data,
    input  logic [6:0]     mem_tag_out,
    input  logic           mem_ack,
    output logic           busy,
    output logic           timeout_err
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state;
    logic [1:0]      last_grant;
    logic [3:0]      pending;
    logic [1:0]      sel;
    logic            ack_hit;
    logic [TO_W-1:0] to_cnt;

    // A requester is pending when any of its read or write lanes is enabled
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            pending[i] = |{req_rd_en[i*4 +: 4], req_wr_en[i*4 +: 4]};
        end
    end

    // Round-robin pick: scan from last_grant+4 down to last_grant+1 so the
    // nearest pending requester after last_grant is the final assignment
    always_comb begin
        sel = last_grant;
        for (int unsigned k = 4; k > 0; k--) begin
            if (pending[last_grant + 2'(k)]) begin
                sel = last_grant + 2'(k);
            end
        end
    end

    // Owner id lives in the upper bits of the latched memory tag
    assign ack_hit = mem_ack && (mem_tag_out[6:5] == mem_tag[6:5]);
    assign busy    = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic timeout_err_q;
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with registered grant, memory request and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 2'd3;
            req_grant    <= '0;
            resp_valid   <= '0;
            resp_tag     <= '0;
            resp_rd_data <= '0;
            mem_rd_en    <= '0;
            mem_wr_en    <= '0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            mem_wr_mask  <= '0;
            mem_tag      <= '0;
            to_cnt       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            req_grant  <= '0;
            resp_valid <= '0;
            mem_rd_en  <= '0;
            mem_wr_en  <= '0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state       <= ISSUE;
                        last_grant  <= sel;
                        req_grant   <= 4'b0001 << sel;
                        mem_rd_en   <= req_rd_en[sel*4 +: 4];
                        mem_wr_en   <= req_wr_en[sel*4 +: 4];
                        mem_addr    <= req_addr[sel*2048 +: 2048];
                        mem_wr_data <= req_wr_data[sel*8192 +: 8192];
                        mem_wr_mask <= req_wr_mask[sel*64 +: 64];
                        mem_tag     <= {sel, req_tag[sel*5 +: 5]};
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    if (ack_hit) begin
                        state        <= IDLE;
                        resp_valid   <= 4'b0001 << mem_tag[6:5];
                        resp_tag     <= mem_tag_out[4:0];
                        resp_rd_data <= mem_rd_data;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        state        <= IDLE;
                        resp_valid   <= 4'b0001 << mem_tag[6:5];
                        resp_tag     <= mem_tag_out[4:0];
                        resp_rd_data <= mem_rd_data;
                    end else begin
                        // Counter always runs in WAIT; expiry only acts when the timeout is built in
                        to_cnt <= to_cnt + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        if (to_cnt == TO_LAST) begin
                            state         <= IDLE;
                            timeout_err_q <= 1'b1;
                            resp_valid    <= 4'b0001 << mem_tag[6:5];
                            resp_tag      <= mem_tag[4:0];
                            resp_rd_data  <= '0;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter. Requests are
// held in per-requester model arrays; the expected winner is recomputed from
// the round-robin rule over whatever is pending.
module tb_mem_arbiter;

    logic           clk;
    logic           rst;
    logic [15:0]    req_rd_en;
    logic [15:0]    req_wr_en;
    logic [8191:0]  req_addr;
    logic [32767:0] req_wr_data;
    logic [255:0]   req_wr_mask;
    logic [19:0]    req_tag;
    logic [3:0]     req_grant;
    logic [3:0]     resp_valid;
    logic [4:0]     resp_tag;
    logic [8191:0]  resp_rd_data;
    logic [3:0]     mem_rd_en;
    logic [3:0]     mem_wr_en;
    logic [2047:0]  mem_addr;
    logic [8191:0]  mem_wr_data;
    logic [63:0]    mem_wr_mask;
    logic [6:0]     mem_tag;
    logic [8191:0]  mem_rd_data;
    logic [6:0]     mem_tag_out;
    logic           mem_ack;
    logic           busy;
    logic           timeout_err;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_wr_mask(req_wr_mask), .req_tag(req_tag),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_rd_data(resp_rd_data), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_tag(mem_tag), .mem_rd_data(mem_rd_data), .mem_tag_out(mem_tag_out),
        .mem_ack(mem_ack), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current request of each requester, and last winner
    logic [3:0]    m_rd   [4];
    logic [3:0]    m_wr   [4];
    logic [2047:0] m_addr [4];
    logic [8191:0] m_data [4];
    logic [63:0]   m_mask [4];
    logic [4:0]    m_tag  [4];
    int            m_last;

    int checks;
    int errors;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < 4; i++) begin
            req_rd_en[i*4 +: 4]         = m_rd[i];
            req_wr_en[i*4 +: 4]         = m_wr[i];
            req_addr[i*2048 +: 2048]    = m_addr[i];
            req_wr_data[i*8192 +: 8192] = m_data[i];
            req_wr_mask[i*64 +: 64]     = m_mask[i];
            req_tag[i*5 +: 5]           = m_tag[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_rd[i] = '0; m_wr[i] = '0; m_addr[i] = '0;
            m_data[i] = '0; m_mask[i] = '0; m_tag[i] = '0;
        end
    endtask

    // Random payload; lanes may be zero (not pending) unless force_on is set
    task automatic rand_req(input int i, input bit force_on);
        for (int w = 0; w < 64; w++)  m_addr[i][w*32 +: 32] = $urandom();
        for (int w = 0; w < 256; w++) m_data[i][w*32 +: 32] = $urandom();
        m_mask[i] = {$urandom(), $urandom()};
        m_tag[i]  = 5'($urandom());
        m_rd[i]   = 4'($urandom());
        m_wr[i]   = 4'($urandom());
        if (force_on && m_rd[i] == 4'd0 && m_wr[i] == 4'd0) m_wr[i] = 4'($urandom_range(15, 1));
    endtask

    function automatic logic [3:0] pend_vec();
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = (m_rd[i] != 4'd0) || (m_wr[i] != 4'd0);
        return p;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] pend);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        clear_model();
        apply_reqs();
        mem_ack = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_last = 3;
    endtask

    // One full transaction: grant, hold/clear/change request, optional
    // wrong-id acks (noise 1 = random, 2 = every cycle), then matching ack.
    // delay = cycles spent in ISSUE/WAIT before the matching ack is driven.
    task automatic do_txn(input int delay, input int mode, input int noise, input int rtag_sel);
        int            exp_id;
        int            wrong;
        bit            seen;
        logic [2047:0] e_addr;
        logic [6:0]    e_tag;
        logic [4:0]    rtag;
        logic [8191:0] rdata;
        exp_id = rr_pick(m_last, pend_vec());
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (req_grant !== 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || exp_id < 0) begin
            errors++;
            $display("FAIL grant_wait: req_grant=%b after 8 cycles, required grant to requester %0d", req_grant, exp_id);
            return;
        end
        e_addr = m_addr[exp_id];
        e_tag  = {2'(exp_id), m_tag[exp_id]};
        checks++;
        if (req_grant !== (4'b0001 << exp_id)) begin
            errors++; $display("FAIL grant_id: req_grant=%b required %b", req_grant, 4'b0001 << exp_id);
        end
        checks++;
        if (mem_rd_en !== m_rd[exp_id] || mem_wr_en !== m_wr[exp_id]) begin
            errors++; $display("FAIL issue_enables: rd=%b wr=%b required rd=%b wr=%b", mem_rd_en, mem_wr_en, m_rd[exp_id], m_wr[exp_id]);
        end
        checks++;
        if (mem_tag !== e_tag) begin
            errors++; $display("FAIL issue_tag: mem_tag=%h required %h", mem_tag, e_tag);
        end
        checks++;
        if (mem_addr !== e_addr || mem_wr_data !== m_data[exp_id] || mem_wr_mask !== m_mask[exp_id]) begin
            errors++; $display("FAIL issue_payload: addr[31:0]=%h data[31:0]=%h mask=%h required %h %h %h",
                               mem_addr[31:0], mem_wr_data[31:0], mem_wr_mask, e_addr[31:0], m_data[exp_id][31:0], m_mask[exp_id]);
        end
        checks++;
        if (busy !== 1'b1 || resp_valid !== 4'b0000) begin
            errors++; $display("FAIL issue_status: busy=%b resp_valid=%b required 1 0000", busy, resp_valid);
        end
        if (mode == 1) begin
            m_rd[exp_id] = '0; m_wr[exp_id] = '0;
        end else if (mode == 2) begin
            rand_req(exp_id, 1'b0);
        end
        apply_reqs();
        m_last = exp_id;
        for (int d = 0; d < delay; d++) begin
            if (noise == 2 || (noise == 1 && $urandom_range(1) == 1)) begin
                wrong = (exp_id + 1 + int'($urandom_range(2))) % 4;
                mem_ack = 1'b1;
                mem_tag_out = {2'(wrong), 5'($urandom())};
            end else begin
                mem_ack = 1'b0;
            end
            tick();
            mem_ack = 1'b0;
            checks++;
            if (busy !== 1'b1 || resp_valid !== 4'b0000 || req_grant !== 4'b0000 || mem_rd_en !== 4'b0000 ||
                mem_wr_en !== 4'b0000 || mem_tag !== e_tag || mem_addr !== e_addr) begin
                errors++; $display("FAIL wait_hold: busy=%b resp_valid=%b grant=%b rd=%b wr=%b tag=%h required 1 0000 0000 0000 0000 %h",
                                   busy, resp_valid, req_grant, mem_rd_en, mem_wr_en, mem_tag, e_tag);
            end
        end
        rtag = (rtag_sel < 0) ? 5'($urandom()) : 5'(rtag_sel);
        for (int w = 0; w < 256; w++) rdata[w*32 +: 32] = $urandom();
        mem_ack = 1'b1;
        mem_tag_out = {2'(exp_id), rtag};
        mem_rd_data = rdata;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (resp_valid !== (4'b0001 << exp_id) || resp_tag !== rtag) begin
            errors++; $display("FAIL resp: resp_valid=%b resp_tag=%h required %b %h", resp_valid, resp_tag, 4'b0001 << exp_id, rtag);
        end
        checks++;
        if (resp_rd_data !== rdata) begin
            errors++; $display("FAIL resp_data: resp_rd_data[31:0]=%h required %h", resp_rd_data[31:0], rdata[31:0]);
        end
        checks++;
        if (busy !== 1'b0 || req_grant !== 4'b0000) begin
            errors++; $display("FAIL resp_status: busy=%b req_grant=%b required 0 0000", busy, req_grant);
        end
    endtask

    task automatic test_reset();
        clear_model();
        rand_req(2, 1'b1);
        apply_reqs();
        mem_ack = 1'b0;
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (req_grant !== 4'b0000 || resp_valid !== 4'b0000 || mem_rd_en !== 4'b0000 || mem_wr_en !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: grant=%b resp=%b rd=%b wr=%b required all 0", req_grant, resp_valid, mem_rd_en, mem_wr_en);
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b timeout_err=%b required 0 0", busy, timeout_err);
        end
        checks++;
        if (mem_tag !== 7'h00 || resp_tag !== 5'h00 || mem_addr !== '0 || mem_wr_data !== '0 ||
            mem_wr_mask !== '0 || resp_rd_data !== '0) begin
            errors++; $display("FAIL reset_payload: mem_tag=%h resp_tag=%h addr[31:0]=%h required 0", mem_tag, resp_tag, mem_addr[31:0]);
        end
        clear_model();
        apply_reqs();
        rst = 1'b0;
        m_last = 3;
    endtask

    task automatic test_directed();
        clear_model();
        m_wr[1]  = 4'b0101;
        m_tag[1] = 5'd3;
        m_mask[1] = 64'd7;
        for (int j = 0; j < 4; j++) m_addr[1][j*512 +: 512] = 512'(8'h04 + 8'h10 * j);
        for (int w = 0; w < 256; w++) m_data[1][w*32 +: 32] = $urandom();
        apply_reqs();
        do_txn(1, 1, 0, 3);
    endtask

    task automatic test_all_four();
        reset_dut();
        for (int i = 0; i < 4; i++) rand_req(i, 1'b1);
        apply_reqs();
        for (int t = 0; t < 4; t++) do_txn(2, 1, 0, -1);
    endtask

    task automatic test_pair();
        reset_dut();
        rand_req(0, 1'b1);
        rand_req(2, 1'b1);
        apply_reqs();
        for (int t = 0; t < 4; t++) do_txn(1, 0, 0, -1);
        clear_model();
        apply_reqs();
    endtask

    task automatic test_mismatch();
        clear_model();
        rand_req(1, 1'b1);
        apply_reqs();
        do_txn(3, 1, 2, -1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_model();
        rand_req(0, 1'b1);
        apply_reqs();
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (req_grant !== 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || req_grant !== 4'b0001) begin
            errors++; $display("FAIL rstmid_grant: req_grant=%b required 0001", req_grant);
        end
        clear_model();
        apply_reqs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 3;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            errors++; $display("FAIL rstmid_abort: busy=%b resp_valid=%b required 0 0000", busy, resp_valid);
        end
        mem_ack = 1'b1;
        mem_tag_out = {2'd0, 5'($urandom())};
        tick();
        mem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            errors++; $display("FAIL rstmid_late_ack: busy=%b resp_valid=%b required 0 0000", busy, resp_valid);
        end
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        apply_reqs();
        do_txn(1, 1, 0, -1);
        clear_model();
        apply_reqs();
    endtask

    task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
        bit         seen;
        logic [4:0] e_tag;
        clear_model();
        rand_req(3, 1'b1);
        apply_reqs();
        e_tag = m_tag[3];
        for (int w = 0; w < 256; w++) mem_rd_data[w*32 +: 32] = $urandom() | 32'h1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (req_grant !== 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || req_grant !== 4'b1000) begin
            errors++; $display("FAIL timeout_grant: req_grant=%b required 1000", req_grant);
        end
        clear_model();
        apply_reqs();
        m_last = 3;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || resp_valid !== 4'b0000 || timeout_err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait: cycle %0d busy=%b resp=%b terr=%b required 1 0000 0", c, busy, resp_valid, timeout_err);
            end
        end
        tick();
        checks++;
        if (resp_valid !== 4'b1000 || resp_tag !== e_tag || resp_rd_data !== '0) begin
            errors++; $display("FAIL timeout_resp: resp_valid=%b tag=%h data[31:0]=%h required 1000 %h 0", resp_valid, resp_tag, resp_rd_data[31:0], e_tag);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: timeout_err=%b busy=%b required 1 0", timeout_err, busy);
        end
        tick(); tick();
        checks++;
        if (timeout_err !== 1'b1 || resp_valid !== 4'b0000) begin
            errors++; $display("FAIL timeout_sticky: timeout_err=%b resp_valid=%b required 1 0000", timeout_err, resp_valid);
        end
`else
        clear_model();
        rand_req(3, 1'b1);
        apply_reqs();
        do_txn(20, 1, 0, -1);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL no_timeout: timeout_err=%b required 0", timeout_err);
        end
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(2) == 0) rand_req(i, 1'b0);
            end
            if (pend_vec() == 4'b0000) rand_req(int'($urandom_range(3)), 1'b1);
            apply_reqs();
            do_txn(int'($urandom_range(4)), int'($urandom_range(2)), 1, -1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_tag_out = '0;
        mem_rd_data = '0;
        clear_model();
        apply_reqs();
        m_last = 3;
        test_reset();
        test_directed();
        test_all_four();
        test_pair();
        test_mismatch();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
